// File: rtl/hazard_pkg.sv
// Shared types and constants for the LEGv8 pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  localparam logic [4:0] XZR = 5'd31;
  localparam int DEF_MEM_TIMEOUT = 255;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; load forces the value 1 and wins over inc.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= W'(1);
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage LEGv8 pipeline: load-use interlock,
// branch flush, variable-latency memory wait with timeout halt, perf counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rn,
  input  logic [4:0]       ifid_rm,
  input  logic             ifid_uses_rm,
  input  logic [4:0]       idex_rd,
  input  logic             idex_memtoreg,
  input  logic             exmem_memwrite,
  input  logic             exmem_memtoreg,
  input  logic             branch_taken,
  input  logic             mem_ack,
  output logic             pc_enable,
  output logic             ifid_enable,
  output logic             idex_enable,
  output logic             exmem_enable,
  output logic             memwr_enable,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             mem_req,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state;
  state_t            state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W:0]   wait_plus;
  logic              mem_op;
  logic              load_use;
  logic              timeout;
  logic              wait_load;
  logic              wait_inc;
  logic              stall_inc;

  assign mem_op    = exmem_memwrite | exmem_memtoreg;
  assign load_use  = idex_memtoreg && (idex_rd != XZR) &&
                     ((idex_rd == ifid_rn) || (ifid_uses_rm && (idex_rd == ifid_rm)));
  assign wait_plus = {1'b0, wait_cnt} + {{WAIT_W{1'b0}}, 1'b1};
  assign timeout   = (wait_plus >= MEM_TIMEOUT[WAIT_W:0]);

  // HALT is only left through reset, so the sticky error is simply the state.
  assign mem_error = (state == HALT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    pc_enable    = 1'b0;
    ifid_enable  = 1'b0;
    idex_enable  = 1'b0;
    exmem_enable = 1'b0;
    memwr_enable = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    mem_req      = 1'b0;
    wait_load    = 1'b0;
    wait_inc     = 1'b0;
    if (!reset) begin
      unique case (state)
        RUN: begin
          mem_req = mem_op;
          if (mem_op && !mem_ack) begin
            state_next = MEM_WAIT;
            wait_load  = 1'b1;
          end else if (load_use) begin
            // Hold PC and IF/ID; the bubble lets the load drain out of EX.
            idex_bubble  = 1'b1;
            idex_enable  = 1'b1;
            exmem_enable = 1'b1;
            memwr_enable = 1'b1;
          end else begin
            pc_enable    = 1'b1;
            ifid_enable  = 1'b1;
            idex_enable  = 1'b1;
            exmem_enable = 1'b1;
            memwr_enable = 1'b1;
            ifid_flush   = branch_taken;
          end
        end
        MEM_WAIT: begin
          mem_req      = 1'b1;
          pc_enable    = mem_ack;
          ifid_enable  = mem_ack;
          idex_enable  = mem_ack;
          exmem_enable = mem_ack;
          memwr_enable = mem_ack;
          if (mem_ack) begin
            state_next = RUN;
          end else begin
            wait_inc = 1'b1;
            if (timeout) begin
              state_next = HALT;
            end
          end
        end
        HALT: begin
          state_next = HALT;
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  assign stall_inc = !pc_enable && (state != HALT);

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (wait_load),
    .inc   (wait_inc),
    .count (wait_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (1'b0),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (1'b0),
    .inc   (ifid_flush),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: behavioural model of the hazard rules plus directed literal checks.
module tb_pipeline_hazard_ctrl;

  localparam int T    = 4;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  typedef struct packed {
    logic pc, ifid, idex, exmem, memwr, flush, bubble, req, err;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [4:0]    ifid_rn, ifid_rm, idex_rd;
  logic          ifid_uses_rm, idex_memtoreg, exmem_memwrite, exmem_memtoreg;
  logic          branch_taken, mem_ack;
  logic          pc_enable, ifid_enable, idex_enable, exmem_enable, memwr_enable;
  logic          ifid_flush, idex_bubble, mem_req, mem_error;
  logic [CW-1:0] stall_cycles, flush_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: whether an access is outstanding, for how many cycles, halted, counters.
  bit m_waiting = 0;
  bit m_halted  = 0;
  int m_out     = 0;
  int m_stall   = 0;
  int m_flush   = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .ifid_rn        (ifid_rn),
    .ifid_rm        (ifid_rm),
    .ifid_uses_rm   (ifid_uses_rm),
    .idex_rd        (idex_rd),
    .idex_memtoreg  (idex_memtoreg),
    .exmem_memwrite (exmem_memwrite),
    .exmem_memtoreg (exmem_memtoreg),
    .branch_taken   (branch_taken),
    .mem_ack        (mem_ack),
    .pc_enable      (pc_enable),
    .ifid_enable    (ifid_enable),
    .idex_enable    (idex_enable),
    .exmem_enable   (exmem_enable),
    .memwr_enable   (memwr_enable),
    .ifid_flush     (ifid_flush),
    .idex_bubble    (idex_bubble),
    .mem_req        (mem_req),
    .mem_error      (mem_error),
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  function automatic exp_t model_eval();
    exp_t e;
    logic mem_op, dep;
    e      = '0;
    mem_op = exmem_memwrite | exmem_memtoreg;
    dep    = idex_memtoreg && (idex_rd != 5'd31) &&
             ((idex_rd == ifid_rn) || (ifid_uses_rm && (idex_rd == ifid_rm)));
    if (m_halted) begin
      e.err = 1'b1;
    end else if (m_waiting) begin
      e.req = 1'b1;
      {e.pc, e.ifid, e.idex, e.exmem, e.memwr} = {5{mem_ack}};
    end else begin
      e.req = mem_op;
      if (!(mem_op && !mem_ack)) begin
        if (dep) begin
          e.bubble = 1'b1;
          {e.idex, e.exmem, e.memwr} = 3'b111;
        end else begin
          {e.pc, e.ifid, e.idex, e.exmem, e.memwr} = 5'b11111;
          e.flush = branch_taken;
        end
      end
    end
    return e;
  endfunction

  always @(posedge clk or posedge reset) begin
    exp_t e;
    if (reset) begin
      m_waiting <= 0;
      m_halted  <= 0;
      m_out     <= 0;
      m_stall   <= 0;
      m_flush   <= 0;
    end else begin
      e = model_eval();
      if (!m_halted) begin
        if (!e.pc && m_stall < MAXC) m_stall <= m_stall + 1;
        if (e.flush && m_flush < MAXC) m_flush <= m_flush + 1;
      end
      if (m_waiting) begin
        if (mem_ack) begin
          m_waiting <= 0;
        end else begin
          m_out <= m_out + 1;
          if (m_out + 1 >= T) begin
            m_waiting <= 0;
            m_halted  <= 1;
          end
        end
      end else if (!m_halted && (exmem_memwrite || exmem_memtoreg) && !mem_ack) begin
        m_waiting <= 1;
        m_out     <= 1;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    e = reset ? exp_t'('0) : model_eval();
    check("pc_enable",    pc_enable,    e.pc);
    check("ifid_enable",  ifid_enable,  e.ifid);
    check("idex_enable",  idex_enable,  e.idex);
    check("exmem_enable", exmem_enable, e.exmem);
    check("memwr_enable", memwr_enable, e.memwr);
    check("ifid_flush",   ifid_flush,   e.flush);
    check("idex_bubble",  idex_bubble,  e.bubble);
    check("mem_req",      mem_req,      e.req);
    check("mem_error",    mem_error,    e.err);
    check("stall_cycles", stall_cycles, reset ? 0 : m_stall);
    check("flush_count",  flush_count,  reset ? 0 : m_flush);
  end

  task automatic clr_in();
    ifid_rn = 0; ifid_rm = 0; ifid_uses_rm = 0; idex_rd = 0; idex_memtoreg = 0;
    exmem_memwrite = 0; exmem_memtoreg = 0; branch_taken = 0; mem_ack = 0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use();
    clr_in();
    idex_memtoreg = 1; idex_rd = 5; ifid_rn = 5;
  endtask

  initial begin
    clr_in();
    #2;
    check("rst_pc_enable", pc_enable, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_stall", stall_cycles, 0);
    next(); next();
    reset = 0;
    @(negedge clk);
    check("idle_pc_enable", pc_enable, 1);

    // load-use
    next(); set_load_use();
    @(negedge clk);
    check("lu_pc_enable", pc_enable, 0);
    check("lu_ifid_enable", ifid_enable, 0);
    check("lu_bubble", idex_bubble, 1);
    check("lu_idex_enable", idex_enable, 1);
    next(); clr_in();
    @(negedge clk);
    check("lu_stall_after", stall_cycles, 1);
    check("lu_pc_after", pc_enable, 1);

    // XZR and rm gating
    next(); idex_memtoreg = 1; idex_rd = 31; ifid_rn = 31;
    @(negedge clk);
    check("xzr_no_stall", pc_enable, 1);
    next(); idex_rd = 7; ifid_rm = 7; ifid_rn = 0; ifid_uses_rm = 0;
    @(negedge clk);
    check("rm_unused_no_stall", pc_enable, 1);
    next(); ifid_uses_rm = 1;
    @(negedge clk);
    check("rm_used_stall", pc_enable, 0);

    // priority: load-use beats branch
    next(); branch_taken = 1;
    @(negedge clk);
    check("prio_flush", ifid_flush, 0);
    next(); clr_in(); branch_taken = 1;
    @(negedge clk);
    check("branch_flush", ifid_flush, 1);
    check("branch_pc", pc_enable, 1);
    next(); clr_in();
    @(negedge clk);
    check("flush_count_1", flush_count, 1);
    check("stall_3", stall_cycles, 3);

    // memory wait, ack on 4th cycle
    next(); exmem_memtoreg = 1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("mw_pc_enable", pc_enable, 0);
      check("mw_memwr_enable", memwr_enable, 0);
      check("mw_mem_req", mem_req, 1);
      if (k < 3) next();
    end
    next(); mem_ack = 1;
    @(negedge clk);
    check("mw_ack_pc", pc_enable, 1);
    check("mw_ack_req", mem_req, 1);
    next(); clr_in();
    @(negedge clk);
    check("mw_stall_6", stall_cycles, 6);

    // same-cycle ack costs nothing
    next(); exmem_memwrite = 1; mem_ack = 1;
    @(negedge clk);
    check("ack0_pc", pc_enable, 1);
    check("ack0_req", mem_req, 1);
    next(); clr_in();
    @(negedge clk);
    check("ack0_stall", stall_cycles, 6);

    // randomized phase; halts are cleared by a reset pulse
    for (int i = 0; i < 400; i++) begin
      next();
      reset          = m_halted;
      idex_rd        = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      ifid_rn        = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      ifid_rm        = 5'($urandom_range(0, 7));
      ifid_uses_rm   = ($urandom_range(0, 1) == 1);
      idex_memtoreg  = ($urandom_range(0, 9) < 3);
      exmem_memwrite = ($urandom_range(0, 9) < 2);
      exmem_memtoreg = ($urandom_range(0, 9) < 2);
      branch_taken   = ($urandom_range(0, 9) < 2);
      mem_ack        = ($urandom_range(0, 9) < 6);
    end

    // timeout into HALT
    next(); reset = 1; clr_in();
    next(); reset = 0;
    @(negedge clk);
    check("pre_to_stall", stall_cycles, 0);
    next(); exmem_memtoreg = 1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("to_pc_enable", pc_enable, 0);
      check("to_mem_req", mem_req, 1);
      check("to_mem_error", mem_error, 0);
      next();
    end
    @(negedge clk);
    check("halt_error", mem_error, 1);
    check("halt_req", mem_req, 0);
    check("halt_pc", pc_enable, 0);
    check("halt_stall", stall_cycles, 4);
    next(); mem_ack = 1;
    @(negedge clk);
    check("halt_hold_ifid", ifid_enable, 0);
    check("halt_hold_error", mem_error, 1);
    check("halt_hold_stall", stall_cycles, 4);

    // asynchronous reset mid-MEM_WAIT
    next(); reset = 1; clr_in();
    next(); reset = 0;
    next(); exmem_memtoreg = 1;
    @(negedge clk);
    check("arst_req_1", mem_req, 1);
    next();
    @(negedge clk);
    check("arst_wait_pc", pc_enable, 0);
    check("arst_wait_stall", stall_cycles, 1);
    #2 reset = 1;
    #1;
    check("arst_req", mem_req, 0);
    check("arst_pc", pc_enable, 0);
    check("arst_stall", stall_cycles, 0);
    check("arst_error", mem_error, 0);
    next(); reset = 0; clr_in();
    @(negedge clk);
    check("arst_run_pc", pc_enable, 1);
    check("arst_run_req", mem_req, 0);
    check("arst_run_stall", stall_cycles, 0);

    // counter saturation
    next(); set_load_use();
    repeat (16) next();
    clr_in();
    @(negedge clk);
    check("sat_stall", stall_cycles, MAXC);
    check("sat_pc", pc_enable, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
